// File: rtl/udp_frame_tx_if.sv
// Bundles the header-RAM fetch bus, the GMII-style transmit pair and the
// frame control/status handshake of the UDP frame transmitter.
interface udp_frame_tx_if;
  logic       start;
  logic [7:0] hdr_addr;
  logic       hdr_rd_en;
  logic [7:0] hdr_data;
  logic [7:0] txd;
  logic       tx_en;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    input  hdr_data,
    output hdr_addr,
    output hdr_rd_en,
    output txd,
    output tx_en,
    output busy,
    output done
  );

  modport slave (
    output start,
    output hdr_data,
    input  hdr_addr,
    input  hdr_rd_en,
    input  txd,
    input  tx_en,
    input  busy,
    input  done
  );
endinterface

// File: rtl/udp_frame_tx.sv
// Byte-serial Ethernet transmitter: preamble/SFD, header RAM bytes, zero pad,
// CRC-32 FCS, then the inter-frame gap before another start is taken.
module udp_frame_tx #(
  parameter int FRAME_LEN = 50,
  parameter int MIN_FRAME = 60,
  parameter int IFG       = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  udp_frame_tx_if.master   bus
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam bit          HAS_PAD  = (MIN_FRAME > FRAME_LEN);
  localparam int          PAD_LEN  = HAS_PAD ? (MIN_FRAME - FRAME_LEN) : 1;
  localparam logic [7:0]  LAST_PRE = 8'd6;
  localparam logic [7:0]  LAST_HDR = 8'(FRAME_LEN - 1);
  localparam logic [7:0]  LAST_PAD = 8'(PAD_LEN - 1);
  localparam logic [7:0]  LAST_FCS = 8'd3;
  localparam logic [7:0]  LAST_GAP = 8'(IFG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_HDR,
    S_PAD,
    S_FCS,
    S_GAP
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] crc_reg, crc_next;
  logic [7:0]  txd_reg, txd_next;
  logic        tx_en_reg, tx_en_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic        hdr_fetch;
  logic [7:0]  crc_in;
  logic [31:0] crc_chain [0:8];
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;

  // The RAM answers combinationally, so the fetch address is simply the byte
  // counter while in HDR; the byte lands on txd at the closing edge.
  assign hdr_fetch     = (state_reg == S_HDR);
  assign bus.hdr_addr  = hdr_fetch ? cnt_reg : 8'h00;
  assign bus.hdr_rd_en = hdr_fetch;

  assign bus.txd   = txd_reg;
  assign bus.tx_en = tx_en_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;

  // One byte of reflected CRC-32 per cycle, unrolled bit by bit (LSB first).
  assign crc_in       = hdr_fetch ? bus.hdr_data : 8'h00;
  assign crc_chain[0] = crc_reg;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
      assign crc_chain[gi+1] = (crc_chain[gi][0] ^ crc_in[gi])
                             ? ((crc_chain[gi] >> 1) ^ CRC_POLY)
                             : (crc_chain[gi] >> 1);
    end
  endgenerate

  assign fcs_word = ~crc_reg;
  assign fcs_byte = fcs_word[{cnt_reg[1:0], 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 8'h00;
      crc_reg   <= CRC_INIT;
      txd_reg   <= 8'h00;
      tx_en_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      crc_reg   <= crc_next;
      txd_reg   <= txd_next;
      tx_en_reg <= tx_en_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    crc_next   = crc_reg;
    txd_next   = 8'h00;
    tx_en_next = 1'b0;
    done_next  = 1'b0;
    // Registered from the current state so busy drops one edge after GAP
    // ends, the same edge at which a waiting start is accepted.
    busy_next  = (state_reg != S_IDLE);

    unique case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_PRE;
          cnt_next   = 8'h00;
        end
      end

      S_PRE: begin
        txd_next   = 8'h55;
        tx_en_next = 1'b1;
        crc_next   = CRC_INIT;
        if (cnt_reg == LAST_PRE) begin
          state_next = S_SFD;
          cnt_next   = 8'h00;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      S_SFD: begin
        txd_next   = 8'hD5;
        tx_en_next = 1'b1;
        state_next = S_HDR;
        cnt_next   = 8'h00;
      end

      S_HDR: begin
        txd_next   = bus.hdr_data;
        tx_en_next = 1'b1;
        crc_next   = crc_chain[8];
        if (cnt_reg == LAST_HDR) begin
          state_next = HAS_PAD ? S_PAD : S_FCS;
          cnt_next   = 8'h00;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      S_PAD: begin
        txd_next   = 8'h00;
        tx_en_next = 1'b1;
        crc_next   = crc_chain[8];
        if (cnt_reg == LAST_PAD) begin
          state_next = S_FCS;
          cnt_next   = 8'h00;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      S_FCS: begin
        txd_next   = fcs_byte;
        tx_en_next = 1'b1;
        if (cnt_reg == LAST_FCS) begin
          state_next = S_GAP;
          cnt_next   = 8'h00;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      S_GAP: begin
        // First gap cycle is the one in which the frame is reported complete.
        done_next = (cnt_reg == 8'h00);
        if (cnt_reg == LAST_GAP) begin
          state_next = S_IDLE;
          cnt_next   = 8'h00;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_udp_frame_tx.sv
// Checks udp_frame_tx (FRAME_LEN=50 and FRAME_LEN=64 builds) with a timing
// vector table, a byte scoreboard fed by a CRC reference model, and corner sequences.
module tb_udp_frame_tx;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  udp_frame_tx_if if0();
  udp_frame_tx_if if1();

  logic [7:0] ram0 [0:255];
  logic [7:0] ram1 [0:255];

  assign if0.hdr_data = ram0[if0.hdr_addr];
  assign if1.hdr_data = ram1[if1.hdr_addr];

  udp_frame_tx #(.FRAME_LEN(50), .MIN_FRAME(60), .IFG(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.master)
  );

  udp_frame_tx #(.FRAME_LEN(64), .MIN_FRAME(60), .IFG(12)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.master)
  );

  // Ethernet + IPv4 + UDP header (42 bytes), payload 0x01..0x08 follows.
  logic [7:0] hdr_init [0:41] = '{
    8'h00, 8'h1C, 8'hC0, 8'h11, 8'h22, 8'h33, 8'h00, 8'h0A, 8'h35, 8'h01,
    8'h02, 8'h03, 8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h24, 8'h12, 8'h34,
    8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h0A,
    8'hC0, 8'hA8, 8'h01, 8'h14, 8'h04, 8'h00, 8'h04, 8'h01, 8'h00, 8'h10,
    8'h00, 8'h00
  };

  typedef struct {
    int         edge_n;
    logic [7:0] txd;
    logic       en;
    logic       busy;
    logic       dn;
    logic       rd;
    logic [7:0] addr;
  } vec_t;

  vec_t vecs [13];

  int checks   = 0;
  int failures = 0;

  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];
  int          gap_log [$];
  int          starts [2];
  int          frames_done [2];
  int          len [2];
  int          addr_exp [2];
  int          gap_cnt [2];
  logic        prev_en [2];
  logic [31:0] crc_acc [2];

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic int frame_len(input int d);
    return (d == 0) ? 50 : 64;
  endfunction

  function automatic int tx_len(input int d);
    return (d == 0) ? 72 : 76;
  endfunction

  task automatic push_byte(input int d, input logic [7:0] b);
    if (d == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  // Reference frame: preamble, SFD, RAM bytes, zero pad to 60, ~CRC LSB first.
  task automatic push_frame(input int d);
    logic [31:0] c = 32'hFFFFFFFF;
    logic [7:0]  b;
    int          fl = frame_len(d);
    int          body = (fl > 60) ? fl : 60;
    for (int i = 0; i < 7; i++) push_byte(d, 8'h55);
    push_byte(d, 8'hD5);
    for (int i = 0; i < body; i++) begin
      if (i < fl) b = (d == 0) ? ram0[i] : ram1[i];
      else        b = 8'h00;
      c = crc_byte(c, b);
      push_byte(d, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) push_byte(d, c[8*k +: 8]);
  endtask

  task automatic fail_line(input string name, input logic [31:0] act, input logic [31:0] req);
    failures++;
    $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, req, $time);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) fail_line(name, act, req);
  endtask

  // Per-cycle observer for one DUT, sampled on the falling edge.
  task automatic mon(input int d, input logic en, input logic [7:0] txd, input logic dn,
                     input logic rd, input logic [7:0] addr);
    logic [7:0] e;
    string      tag = (d == 0) ? "d50" : "d64";
    if (!rst_n) begin
      if (d == 0) q0.delete(); else q1.delete();
      len[d] = 0; addr_exp[d] = 0; gap_cnt[d] = -1; prev_en[d] = 1'b0;
      return;
    end
    if (en) begin
      if (!prev_en[d]) begin
        starts[d]++;
        if (d == 0 && gap_cnt[d] > 0) gap_log.push_back(gap_cnt[d]);
      end
      checks++;
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        fail_line({tag, "_unexpected_byte"}, {24'h0, txd}, 32'h0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (txd !== e) fail_line({tag, "_txd_byte"}, {24'h0, txd}, {24'h0, e});
        else $display("%s byte %0d txd=%02h ok", tag, len[d], txd);
      end
      if (len[d] == 0) crc_acc[d] = 32'hFFFFFFFF;
      if (len[d] >= 8) crc_acc[d] = crc_byte(crc_acc[d], txd);
      len[d]++;
    end else if (prev_en[d]) begin
      check({tag, "_tx_en_cycles"}, len[d], tx_len(d));
      check({tag, "_crc_residue"}, crc_acc[d], 32'hDEBB20E3);
      check({tag, "_done_at_end"}, {31'h0, dn}, 32'h1);
      check({tag, "_addr_sweep"}, addr_exp[d], frame_len(d));
      check({tag, "_txd_zero_idle"}, {24'h0, txd}, 32'h0);
      $display("%s frame end len=%0d residue=%08h", tag, len[d], crc_acc[d]);
      frames_done[d]++;
      len[d] = 0; addr_exp[d] = 0; gap_cnt[d] = 1;
    end else begin
      if (dn)          fail_line({tag, "_spurious_done"}, 32'h1, 32'h0);
      if (txd != 8'h0) fail_line({tag, "_txd_nonzero_idle"}, {24'h0, txd}, 32'h0);
      if (gap_cnt[d] > 0) gap_cnt[d]++;
    end
    if (rd) begin
      checks++;
      if (addr !== 8'(addr_exp[d])) fail_line({tag, "_hdr_addr"}, {24'h0, addr}, addr_exp[d]);
      addr_exp[d]++;
    end else if (addr !== 8'h00) begin
      fail_line({tag, "_addr_not_zero"}, {24'h0, addr}, 32'h0);
    end
    prev_en[d] = en;
  endtask

  task automatic mon_loop();
    forever begin
      @(negedge clk);
      mon(0, if0.tx_en, if0.txd, if0.done, if0.hdr_rd_en, if0.hdr_addr);
      mon(1, if1.tx_en, if1.txd, if1.done, if1.hdr_rd_en, if1.hdr_addr);
    end
  endtask

  function automatic int get_cnt(input int sel);
    case (sel)
      0:       return starts[0];
      1:       return frames_done[0];
      default: return frames_done[1];
    endcase
  endfunction

  task automatic wait_ge(input int sel, input int target, input int budget, input string name);
    int n = 0;
    while (get_cnt(sel) < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, get_cnt(sel), target);
  endtask

  // Start is sampled at the following rising edge (edge 0); returns at edge0+1.
  task automatic start_pulse(input int d);
    @(negedge clk);
    if (d == 0) if0.start = 1'b1; else if1.start = 1'b1;
    @(posedge clk);
    #1;
    if (d == 0) if0.start = 1'b0; else if1.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_d50"}, {12'h0, if0.txd, if0.tx_en, if0.busy, if0.done, if0.hdr_rd_en, if0.hdr_addr}, 32'h0);
    check({name, "_d64"}, {12'h0, if1.txd, if1.tx_en, if1.busy, if1.done, if1.hdr_rd_en, if1.hdr_addr}, 32'h0);
  endtask

  initial begin
    int cur;
    int base_s;
    int base_f;
    int gbase;
    logic [19:0] act;
    logic [19:0] req;

    rst_n = 1'b0;
    if0.start = 1'b0;
    if1.start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 8'h00;
      ram1[i] = 8'(i) ^ 8'hA5;
    end
    for (int i = 0; i < 42; i++) ram0[i] = hdr_init[i];
    for (int i = 0; i < 8; i++)  ram0[42+i] = 8'(i + 1);

    // edge, txd, tx_en, busy, done, hdr_rd_en, hdr_addr (sampled just after the edge)
    vecs[0]  = '{0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1,  8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{7,  8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{8,  8'hD5, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
    vecs[4]  = '{9,  8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[5]  = '{10, 8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[6]  = '{50, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'd42};
    vecs[7]  = '{58, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{59, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{73, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[10] = '{74, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{84, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{85, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    fork
      mon_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reference frame against the timing table (scoreboard checks every byte).
    push_frame(0);
    start_pulse(0);
    cur = 0;
    for (int i = 0; i < 13; i++) begin
      while (cur < vecs[i].edge_n) begin
        @(posedge clk);
        cur++;
        #1;
      end
      act = {if0.txd, if0.tx_en, if0.busy, if0.done, if0.hdr_rd_en, if0.hdr_addr};
      req = {vecs[i].txd, vecs[i].en, vecs[i].busy, vecs[i].dn, vecs[i].rd, vecs[i].addr};
      checks++;
      if (act !== req) fail_line($sformatf("vec_edge%0d", vecs[i].edge_n), {12'h0, act}, {12'h0, req});
      else $display("vec edge %0d outputs=%05h ok", vecs[i].edge_n, act);
    end
    check("frame1_done_count", frames_done[0], 1);

    // Start held high: three back-to-back frames, each gap = IFG cycles plus
    // the single IDLE cycle in which start is sampled.
    repeat (5) @(negedge clk);
    base_s = starts[0];
    base_f = frames_done[0];
    gbase  = gap_log.size();
    push_frame(0); push_frame(0); push_frame(0);
    @(negedge clk);
    if0.start = 1'b1;
    wait_ge(0, base_s + 3, 400, "held_start_third_frame");
    @(negedge clk);
    if0.start = 1'b0;
    wait_ge(1, base_f + 3, 300, "held_start_frames_done");
    check("held_start_gap_count", gap_log.size(), gbase + 3);
    if (gap_log.size() >= gbase + 3) begin
      check("gap_len_1", gap_log[gbase+1], 13);
      check("gap_len_2", gap_log[gbase+2], 13);
    end
    repeat (20) @(posedge clk);
    check("held_start_no_extra", starts[0], base_s + 3);

    // A start pulse at edge 40 (mid-HDR) must be ignored.
    base_s = starts[0];
    base_f = frames_done[0];
    push_frame(0);
    start_pulse(0);
    repeat (39) @(posedge clk);
    #1;
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    wait_ge(1, base_f + 1, 200, "edge40_frame_done");
    repeat (120) @(posedge clk);
    check("edge40_single_frame", starts[0], base_s + 1);

    // FRAME_LEN=64 build: no pad, 76 tx_en cycles, address sweep 0..63.
    base_f = frames_done[1];
    push_frame(1);
    start_pulse(1);
    wait_ge(2, base_f + 1, 200, "len64_frame_done");
    repeat (20) @(posedge clk);

    // Reset asserted just after edge 30 aborts the frame immediately.
    base_s = starts[0];
    base_f = frames_done[0];
    push_frame(0);
    start_pulse(0);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_mid_hdr");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    check("abort_no_done", frames_done[0], base_f);
    check("abort_no_restart", starts[0], base_s + 1);
    push_frame(0);
    start_pulse(0);
    wait_ge(1, base_f + 1, 200, "post_reset_frame_done");
    repeat (20) @(posedge clk);

    check("scoreboard_empty_d50", q0.size(), 0);
    check("scoreboard_empty_d64", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
